// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters exclusive access to a shared
// register write port for a burst of up to DEPTH beats.
module reg_write_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     en,
    output logic [WIDTH-1:0]         d
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               en_q, en_d;
    logic [WIDTH-1:0]   d_q, d_d;

    logic [IW-1:0]      rr_idx;
    logic [IW-1:0]      sel_idx;
    logic               sel_found;
    logic [IW-1:0]      cur_idx;
    logic [WIDTH-1:0]   beat_data;
    logic               beat;
    logic               last_beat;

    // Scan starts one past the previous owner so it ends up with lowest priority.
    always_comb begin
        rr_idx    = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            rr_idx = IW'((int'(owner_q) + k) % int'(NUM_REQ));
            if (!sel_found && req_valid[rr_idx]) begin
                sel_found = 1'b1;
                sel_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        cur_idx   = '0;
        beat_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) begin
                cur_idx   = IW'(i);
                beat_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign beat      = (state_q == StBusy) && |(req_valid & grant_q);
    assign last_beat = |(req_last & grant_q) || (cnt_q == CW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            en_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        d_d     = d_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StBusy;
                    grant_d = NUM_REQ'(1) << sel_idx;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (beat) begin
                    en_d  = 1'b1;
                    d_d   = beat_data;
                    cnt_d = cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                        grant_d = '0;
                        owner_d = cur_idx;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q == StBusy);
        req_ready = (state_q == StBusy) ? grant_q : '0;
    end

    assign grant = grant_q;
    assign en    = en_q;
    assign d     = d_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: DEPTH=16 and DEPTH=4 instances share stimulus; a per-instance
// behavioural model is compared every cycle, plus constant-table and hand-written sequences.
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   last = '0;
    logic [N*W-1:0] data = '0;

    logic [N-1:0] ready_a, grant_a, ready_b, grant_b;
    logic         busy_a, en_a, busy_b, en_b;
    logic [W-1:0] d_a, d_b;

    reg_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .req_valid(valid), .req_data(data), .req_last(last),
        .req_ready(ready_a), .grant(grant_a), .busy(busy_a), .en(en_a), .d(d_a)
    );

    reg_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .DEPTH(4)) dut_d4 (
        .clk(clk), .rst(rst), .req_valid(valid), .req_data(data), .req_last(last),
        .req_ready(ready_b), .grant(grant_b), .busy(busy_b), .en(en_b), .d(d_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model state: owner index (-1 idle), previous owner, beats in burst, expected en/d.
    int           owner[2];
    int           lastown[2];
    int           beats[2];
    int           depth_of[2];
    logic         men[2];
    logic [W-1:0] md[2];
    int           accepted[2];
    int           en_cnt[2];

    logic         fair_on = 1'b0;
    int           waits[N];
    logic [N-1:0] prev_grant_a = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] mgrant(input int m);
        logic [N-1:0] g;
        g = '0;
        if (owner[m] >= 0) g[owner[m]] = 1'b1;
        return g;
    endfunction

    function automatic logic [N*W-1:0] set_slot(input logic [N*W-1:0] v, input int i,
                                                 input logic [W-1:0] val);
        logic [N*W-1:0] r;
        r = v;
        r[i*W +: W] = val;
        return r;
    endfunction

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                owner[m] = -1; lastown[m] = N - 1; beats[m] = 0; men[m] = 1'b0; md[m] = '0;
            end else if (owner[m] < 0) begin
                men[m] = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (lastown[m] + k) % N;
                    if (owner[m] < 0 && valid[c]) begin
                        owner[m] = c;
                        beats[m] = 0;
                    end
                end
            end else if (valid[owner[m]]) begin
                men[m] = 1'b1;
                md[m]  = data[owner[m]*W +: W];
                beats[m]++;
                accepted[m]++;
                if (last[owner[m]] || beats[m] == depth_of[m]) begin
                    lastown[m] = owner[m];
                    owner[m]   = -1;
                end
            end else begin
                men[m] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("grant_a", grant_a, mgrant(0));
        chk("busy_a", busy_a, owner[0] >= 0);
        chk("ready_a", ready_a, mgrant(0));
        chk("en_a", en_a, men[0]);
        chk("d_a", d_a, md[0]);
        chk("onehot_a", $onehot0(grant_a), 1);
        chk("grant_b", grant_b, mgrant(1));
        chk("busy_b", busy_b, owner[1] >= 0);
        chk("ready_b", ready_b, mgrant(1));
        chk("en_b", en_b, men[1]);
        chk("d_b", d_b, md[1]);
        en_cnt[0] += int'(en_a);
        en_cnt[1] += int'(en_b);
        if (grant_a != '0 && prev_grant_a == '0 && fair_on) begin
            for (int j = 0; j < N; j++) begin
                if (grant_a[j]) waits[j] = 0;
                else begin
                    waits[j]++;
                    chk("fair_wait", waits[j] <= N, 1);
                end
            end
        end
        prev_grant_a = grant_a;
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [N*W-1:0] dat);
        rst = r; valid = v; last = l; data = dat;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic [N-1:0] eg;
        logic         ee;
        logic [W-1:0] ed;
    } vec_t;

    vec_t tbl[11];
    logic [N*W-1:0] dfix;
    logic [N*W-1:0] dv;

    initial begin
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1; lastown[m] = N - 1; beats[m] = 0; men[m] = 1'b0; md[m] = '0;
            accepted[m] = 0; en_cnt[m] = 0;
        end
        depth_of[0] = 16;
        depth_of[1] = 4;
        for (int j = 0; j < N; j++) waits[j] = 0;

        // All requesters valid with last: single-beat grants rotating, one idle cycle between.
        tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 16'h0100};
        tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 4'b0010, 1'b0, 16'h0100};
        tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 16'h0101};
        tbl[5]  = '{1'b0, 4'b1111, 4'b1111, 4'b0100, 1'b0, 16'h0101};
        tbl[6]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 16'h0102};
        tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b0, 16'h0102};
        tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 16'h0103};
        tbl[9]  = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 1'b0, 16'h0103};
        tbl[10] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 16'h0100};
        dfix = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].l, dfix);
            chk("tbl_grant", grant_a, tbl[i].eg);
            chk("tbl_busy", busy_a, |tbl[i].eg);
            chk("tbl_en", en_a, tbl[i].ee);
            chk("tbl_d", d_a, tbl[i].ed);
            chk("tbl_grant_d4", grant_b, tbl[i].eg);
        end

        // Requester 2 alone, 5-beat burst 0xA0..0xA4.
        dv = {16'hdead, 16'h0000, 16'hbeef, 16'hcafe};
        cycle(1'b0, 4'b0100, 4'b0000, set_slot(dv, 2, 16'h00A0));
        chk("b5_grant0", grant_a, 4'b0100);
        chk("b5_en0", en_a, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0100, (i == 4) ? 4'b0100 : 4'b0000,
                  set_slot(dv, 2, 16'h00A0 + 16'(i)));
            chk("b5_en", en_a, 1'b1);
            chk("b5_d", d_a, 16'h00A0 + 16'(i));
            chk("b5_grant", grant_a, (i < 4) ? 4'b0100 : 4'b0000);
        end
        cycle(1'b0, 4'b0000, 4'b0000, dv);
        chk("b5_idle_grant", grant_a, 4'b0000);
        chk("b5_idle_en", en_a, 1'b0);
        chk("b5_hold_d", d_a, 16'h00A4);

        // Requester 0 drops valid for 3 cycles mid-burst while others request.
        cycle(1'b1, 4'b0000, 4'b0000, dv);
        cycle(1'b0, 4'b0001, 4'b0000, set_slot(dv, 0, 16'h0011));
        chk("drop_grant0", grant_a, 4'b0001);
        cycle(1'b0, 4'b0001, 4'b0000, set_slot(dv, 0, 16'h0011));
        chk("drop_beat1", en_a, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'b1110, 4'b1110, set_slot(dv, 0, 16'h0055));
            chk("drop_grant", grant_a, 4'b0001);
            chk("drop_ready", ready_a, 4'b0001);
            chk("drop_en", en_a, 1'b0);
            chk("drop_d", d_a, 16'h0011);
        end
        cycle(1'b0, 4'b0001, 4'b0001, set_slot(dv, 0, 16'h0012));
        chk("drop_last_en", en_a, 1'b1);
        chk("drop_last_d", d_a, 16'h0012);
        chk("drop_release", grant_a, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000, dv);

        // DEPTH=4 instance: requester 1 streams without last, requester 3 joins.
        cycle(1'b1, 4'b0000, 4'b0000, dv);
        cycle(1'b0, 4'b0010, 4'b0000, set_slot(dv, 1, 16'h0020));
        chk("d4_grant1", grant_b, 4'b0010);
        for (int b = 0; b < 4; b++) begin
            cycle(1'b0, (b >= 1) ? 4'b1010 : 4'b0010, 4'b1000,
                  set_slot(set_slot(dv, 1, 16'h0021 + 16'(b)), 3, 16'h0030));
            chk("d4_en", en_b, 1'b1);
            chk("d4_d", d_b, 16'h0021 + 16'(b));
            chk("d4_grant", grant_b, (b < 3) ? 4'b0010 : 4'b0000);
        end
        cycle(1'b0, 4'b1010, 4'b1000, set_slot(set_slot(dv, 1, 16'h0025), 3, 16'h0030));
        chk("d4_grant3", grant_b, 4'b1000);
        chk("d4_idle_en", en_b, 1'b0);
        cycle(1'b0, 4'b1010, 4'b1000, set_slot(set_slot(dv, 1, 16'h0025), 3, 16'h0030));
        chk("d4_r3_en", en_b, 1'b1);
        chk("d4_r3_d", d_b, 16'h0030);
        chk("d4_r3_rel", grant_b, 4'b0000);
        cycle(1'b0, 4'b0010, 4'b0000, set_slot(dv, 1, 16'h0026));
        chk("d4_resume1", grant_b, 4'b0010);

        // Reset during beat 2 of a burst by requester 3.
        cycle(1'b1, 4'b0000, 4'b0000, dv);
        cycle(1'b0, 4'b1000, 4'b0000, set_slot(dv, 3, 16'h0041));
        chk("rst_grant3", grant_a, 4'b1000);
        cycle(1'b0, 4'b1000, 4'b0000, set_slot(dv, 3, 16'h0041));
        chk("rst_beat1", en_a, 1'b1);
        cycle(1'b1, 4'b1000, 4'b0000, set_slot(dv, 3, 16'h0042));
        chk("rst_grant", grant_a, 4'b0000);
        chk("rst_en", en_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_d", d_a, 16'h0000);
        cycle(1'b0, 4'b1111, 4'b0000, dv);
        chk("rst_first", grant_a, 4'b0001);

        // Continuous all-valid random traffic with fairness tracking.
        fair_on = 1'b1;
        for (int j = 0; j < N; j++) waits[j] = 0;
        for (int i = 0; i < 10000; i++) begin
            cycle(1'b0, 4'b1111, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  {$urandom, $urandom});
        end
        fair_on = 1'b0;

        // Sparse random valid, rare last, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                  {$urandom, $urandom});
        end

        chk("en_count_a", en_cnt[0], accepted[0]);
        chk("en_count_b", en_cnt[1], accepted[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
